// File: rtl/isp_src_frame_ctrl.sv
// Raw-Bayer frame sequencer: walks the pixel store in raster order with
// programmable H/V blanking and emits a valid/ready pixel stream with SOF/EOL/EOF.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; no reads issued
// S_LINE   | issuing reads for the active pixels of the current line
// S_HBLANK | H_BLANK idle cycles after each line
// S_VBLANK | V_BLANK*(IW+H_BLANK) idle cycles after the last line
module isp_src_frame_ctrl #(
    parameter int IW      = 1936,
    parameter int IH      = 1088,
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 4,
    parameter int DW      = 16,
    parameter int AW      = 22
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_single,
    input  logic [3:0]    i_src_sel,
    output logic          o_mem_rd_en,
    output logic [AW-1:0] o_mem_rd_addr,
    input  logic [DW-1:0] i_mem_rd_data,
    output logic          o_pix_valid,
    output logic [DW-1:0] o_pix_data,
    output logic          o_pix_sof,
    output logic          o_pix_eol,
    output logic          o_pix_eof,
    input  logic          i_pix_ready,
    output logic [3:0]    o_cur_sel,
    output logic [7:0]    o_frame_cnt,
    output logic          o_busy
);

    localparam int HW     = (IW > 1) ? $clog2(IW) : 1;
    localparam int VW     = (IH > 1) ? $clog2(IH) : 1;
    localparam int VB_CYC = V_BLANK * (IW + H_BLANK);
    localparam int BW     = $clog2(VB_CYC + 1);

    localparam logic [HW-1:0] H_LAST = HW'(IW - 1);
    localparam logic [VW-1:0] V_LAST = VW'(IH - 1);
    localparam logic [BW-1:0] HB_LD  = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LD  = BW'(VB_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LINE, S_HBLANK, S_VBLANK} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;
    logic [AW-1:0]   r_addr;
    logic [BW-1:0]   r_blk;
    logic            r_stop_pend;
    logic [3:0]      r_cur_sel;
    logic [7:0]      r_frame_cnt;
    logic            r_rd_pend;
    logic [2:0]      r_pend_mk;
    logic [DW+2:0]   r_fifo [2];
    logic            r_wp;
    logic            r_rp;
    logic [1:0]      r_cnt;

    logic            w_pop;
    logic            w_rd_en;
    logic [1:0]      w_slots;
    logic [2:0]      w_mk;
    logic [DW+2:0]   w_head;

    assign w_head  = r_fifo[r_rp];
    assign w_pop   = (r_cnt != 2'd0) && i_pix_ready;
    // Occupancy after this cycle's pop keeps back-to-back reads at full rate.
    assign w_slots = r_cnt - {1'b0, w_pop} + {1'b0, r_rd_pend};
    assign w_rd_en = (r_state == S_LINE) && (w_slots < 2'd2);
    assign w_mk    = {(r_h == '0) && (r_v == '0), r_h == H_LAST, (r_h == H_LAST) && (r_v == V_LAST)};

    assign o_mem_rd_en   = w_rd_en;
    assign o_mem_rd_addr = r_addr;
    assign o_pix_valid   = (r_cnt != 2'd0);
    assign o_pix_data    = w_head[DW+2:3];
    assign o_pix_sof     = w_head[2];
    assign o_pix_eol     = w_head[1];
    assign o_pix_eof     = w_head[0];
    assign o_cur_sel     = r_cur_sel;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_busy        = (r_state != S_IDLE) || o_pix_valid || r_rd_pend;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_LINE;
            S_LINE:   if (w_rd_en && (r_h == H_LAST)) w_state_nxt = S_HBLANK;
            S_HBLANK: if (r_blk == '0) w_state_nxt = (r_v == V_LAST) ? S_VBLANK : S_LINE;
            S_VBLANK: if (r_blk == '0) w_state_nxt = r_stop_pend ? S_IDLE : S_LINE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h         <= '0;
            r_v         <= '0;
            r_addr      <= '0;
            r_blk       <= '0;
            r_stop_pend <= 1'b0;
            r_cur_sel   <= '0;
            r_frame_cnt <= '0;
            r_rd_pend   <= 1'b0;
            r_pend_mk   <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
        end else begin
            r_rd_pend <= w_rd_en;
            r_pend_mk <= w_mk;
            if (w_rd_en) begin
                r_h    <= (r_h == H_LAST) ? '0 : r_h + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cur_sel   <= i_src_sel;
                        r_stop_pend <= i_single | i_stop;
                        r_h         <= '0;
                        r_v         <= '0;
                        r_addr      <= '0;
                    end
                end
                S_LINE: begin
                    if (w_state_nxt == S_HBLANK) r_blk <= HB_LD;
                end
                S_HBLANK: begin
                    if (r_blk == '0) begin
                        if (r_v == V_LAST) r_blk <= VB_LD;
                        else               r_v   <= r_v + 1'b1;
                    end else begin
                        r_blk <= r_blk - 1'b1;
                    end
                end
                S_VBLANK: begin
                    if (r_blk == '0) begin
                        r_v    <= '0;
                        r_addr <= '0;
                        if (!r_stop_pend) r_cur_sel <= i_src_sel;
                    end else begin
                        r_blk <= r_blk - 1'b1;
                    end
                end
                default: ;
            endcase
            if ((r_state != S_IDLE) && i_stop) r_stop_pend <= 1'b1;

            // Read data lands one cycle after the strobe, markers ride along.
            if (r_rd_pend) begin
                r_fifo[r_wp] <= {i_mem_rd_data, r_pend_mk};
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
            if (w_pop && w_head[0]) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

endmodule
